// File: rtl/dft_frame_loader.sv
// Ping-pong framer for the 16-point DFT front end: collects 2N serial samples per bank
// and presents frame A (indices 0..N-1) and frame B (indices N..2N-1) in parallel.
module dft_frame_loader #(
    parameter int DW = 9,
    parameter int N  = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_data,
    input  logic            flush,
    output logic            frame_valid,
    input  logic            frame_ready,
    output logic [N*DW-1:0] fa_flat,
    output logic [N*DW-1:0] fb_flat,
    output logic [15:0]     frame_cnt
);
    localparam int D  = 2 * N;
    localparam int PW = $clog2(D);
    localparam logic [PW-1:0] LAST = PW'(D - 1);

    logic [DW-1:0] mem_q [2][D];
    logic [DW-1:0] mem_d [2][D];
    logic [1:0]    full_q, full_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic          wr_sel_q, wr_sel_d;
    logic          rd_sel_q, rd_sel_d;
    logic [15:0]   cnt_q, cnt_d;
    logic          accept;
    logic          consume;

    assign in_ready    = !rst && !full_q[wr_sel_q];
    assign frame_valid = full_q[rd_sel_q];
    assign frame_cnt   = cnt_q;
    assign accept      = in_valid && in_ready;
    assign consume     = frame_valid && frame_ready;

    // Write and consume always target different banks: the write bank is never full.
    always_comb begin
        mem_d    = mem_q;
        full_d   = full_q;
        wr_ptr_d = wr_ptr_q;
        wr_sel_d = wr_sel_q;
        rd_sel_d = rd_sel_q;
        cnt_d    = cnt_q;
        if (flush) begin
            wr_ptr_d = '0;
        end else if (accept) begin
            mem_d[wr_sel_q][wr_ptr_q] = in_data;
            if (wr_ptr_q == LAST) begin
                wr_ptr_d         = '0;
                full_d[wr_sel_q] = 1'b1;
                wr_sel_d         = !wr_sel_q;
            end else begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
        end
        if (consume) begin
            full_d[rd_sel_q] = 1'b0;
            rd_sel_d         = !rd_sel_q;
            cnt_d            = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < D; i++) begin
                    mem_q[b][i] <= '0;
                end
            end
            full_q   <= '0;
            wr_ptr_q <= '0;
            wr_sel_q <= 1'b0;
            rd_sel_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            full_q   <= full_d;
            wr_ptr_q <= wr_ptr_d;
            wr_sel_q <= wr_sel_d;
            rd_sel_q <= rd_sel_d;
            cnt_q    <= cnt_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_out
            assign fa_flat[DW*gi +: DW] = mem_q[rd_sel_q][gi];
            assign fb_flat[DW*gi +: DW] = mem_q[rd_sel_q][N+gi];
        end
    endgenerate

endmodule

// File: tb/tb_dft_frame_loader.sv
// Scenario bench for dft_frame_loader against a queue-based model of pending frame pairs.
module tb_dft_frame_loader;
    localparam int DW = 9;
    localparam int N  = 16;
    localparam int PW = 2 * N * DW;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [DW-1:0]   in_data = '0;
    logic            flush = 1'b0;
    logic            frame_valid;
    logic            frame_ready = 1'b0;
    logic [N*DW-1:0] fa_flat;
    logic [N*DW-1:0] fb_flat;
    logic [15:0]     frame_cnt;

    int total = 0;
    int bad   = 0;

    // Model: completed pairs waiting for the consumer, and the pair being assembled.
    logic [PW-1:0] pend[$];
    logic [DW-1:0] part[$];
    logic [15:0]   exp_cnt = '0;

    always #5 clk = ~clk;

    dft_frame_loader #(.DW(DW), .N(N)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .flush(flush), .frame_valid(frame_valid),
        .frame_ready(frame_ready), .fa_flat(fa_flat), .fb_flat(fb_flat),
        .frame_cnt(frame_cnt)
    );

    function automatic logic exp_ready();
        return !rst && (pend.size() < 2);
    endfunction

    function automatic logic exp_fv();
        return pend.size() > 0;
    endfunction

    function automatic logic [PW-1:0] exp_pair();
        return (pend.size() > 0) ? pend[0] : '0;
    endfunction

    // Advance the model with the inputs about to be sampled, then cross one clock edge.
    task automatic tick();
        logic acc;
        logic con;
        logic [PW-1:0] pr;
        pr = '0;
        if (rst) begin
            pend.delete();
            part.delete();
            exp_cnt = '0;
        end else begin
            acc = in_valid && (pend.size() < 2);
            con = (pend.size() > 0) && frame_ready;
            if (con) begin
                void'(pend.pop_front());
                exp_cnt = exp_cnt + 16'd1;
            end
            if (flush) begin
                part.delete();
            end else if (acc) begin
                part.push_back(in_data);
                if (part.size() == 2 * N) begin
                    for (int i = 0; i < 2 * N; i++) pr[DW*i +: DW] = part[i];
                    pend.push_back(pr);
                    part.delete();
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_data = 9'h055;
        tick(); tick();
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%0b exp=0", in_ready); end
        total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL reset_frame_valid got=%0b exp=0", frame_valid); end
        total++; if (fa_flat !== '0 || fb_flat !== '0) begin bad++; $display("FAIL reset_data fa=%h fb=%h exp=0", fa_flat, fb_flat); end
        total++; if (frame_cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", frame_cnt); end
        rst = 1'b0; in_valid = 1'b0;
        tick();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready got=%0b exp=1", in_ready); end
    endtask

    task automatic test_stream();
        logic [N*DW-1:0] efa, efb;
        frame_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 2 * N; i++) begin
            in_data = DW'(i);
            tick();
            total++; if (frame_valid !== (i == 2 * N - 1)) begin bad++; $display("FAIL stream_fv idx=%0d got=%0b", i, frame_valid); end
        end
        in_valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            efa[DW*k +: DW] = DW'(k);
            efb[DW*k +: DW] = DW'(N + k);
        end
        total++; if (fa_flat !== efa) begin bad++; $display("FAIL stream_fa got=%h exp=%h", fa_flat, efa); end
        total++; if (fb_flat !== efb) begin bad++; $display("FAIL stream_fb got=%h exp=%h", fb_flat, efb); end
        total++; if (frame_cnt !== 16'd0) begin bad++; $display("FAIL stream_cnt_before got=%0d exp=0", frame_cnt); end
        frame_ready = 1'b1; tick(); frame_ready = 1'b0;
        total++; if (frame_cnt !== 16'd1) begin bad++; $display("FAIL stream_cnt_after got=%0d exp=1", frame_cnt); end
        total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL stream_fv_after got=%0b exp=0", frame_valid); end
    endtask

    task automatic test_backpressure();
        frame_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 4 * N + 1; i++) begin
            in_data = (i < 2 * N) ? 9'h100 : ((i < 4 * N) ? 9'h0ff : 9'h0aa);
            tick();
            total++; if (in_ready !== exp_ready()) begin bad++; $display("FAIL bp_in_ready idx=%0d got=%0b exp=%0b", i, in_ready, exp_ready()); end
        end
        in_valid = 1'b0;
        total++; if (fa_flat !== {N{9'h100}} || fb_flat !== {N{9'h100}}) begin bad++; $display("FAIL bp_first_pair fa=%h fb=%h", fa_flat, fb_flat); end
        frame_ready = 1'b1; tick(); frame_ready = 1'b0;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_after_consume got=%0b exp=1", in_ready); end
        total++; if (frame_valid !== 1'b1) begin bad++; $display("FAIL bp_second_valid got=%0b exp=1", frame_valid); end
        total++; if (fa_flat !== {N{9'h0ff}} || fb_flat !== {N{9'h0ff}}) begin bad++; $display("FAIL bp_second_pair fa=%h fb=%h", fa_flat, fb_flat); end
        frame_ready = 1'b1; tick(); frame_ready = 1'b0;
        // The dropped 65th sample must not have shifted the next pair.
        in_valid = 1'b1;
        for (int i = 0; i < 2 * N; i++) begin
            in_data = DW'($urandom);
            tick();
        end
        in_valid = 1'b0;
        total++; if (frame_valid !== 1'b1 || {fb_flat, fa_flat} !== exp_pair()) begin bad++; $display("FAIL bp_realign fv=%0b got=%h exp=%h", frame_valid, {fb_flat, fa_flat}, exp_pair()); end
        frame_ready = 1'b1; tick(); frame_ready = 1'b0;
    endtask

    task automatic test_continuous();
        rst = 1'b1; tick(); rst = 1'b0;
        frame_ready = 1'b1;
        for (int i = 0; i < 20 * N + 3; i++) begin
            in_valid = (i < 20 * N);
            in_data = DW'(i);
            tick();
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL cont_in_ready cyc=%0d got=%0b exp=1", i, in_ready); end
            total++; if (frame_valid !== exp_fv() || (exp_fv() && {fb_flat, fa_flat} !== exp_pair())) begin bad++; $display("FAIL cont_pair cyc=%0d fv=%0b got=%h exp=%h", i, frame_valid, {fb_flat, fa_flat}, exp_pair()); end
        end
        in_valid = 1'b0; frame_ready = 1'b0;
        total++; if (frame_cnt !== 16'd10) begin bad++; $display("FAIL cont_cnt got=%0d exp=10", frame_cnt); end
    endtask

    task automatic test_flush();
        logic [DW-1:0] first;
        frame_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin in_data = DW'($urandom); tick(); end
        flush = 1'b1; in_data = DW'($urandom); tick(); flush = 1'b0;
        first = DW'($urandom);
        for (int i = 0; i < 2 * N; i++) begin
            in_data = (i == 0) ? first : DW'($urandom);
            tick();
            total++; if (frame_valid !== exp_fv()) begin bad++; $display("FAIL flush_fv idx=%0d got=%0b exp=%0b", i, frame_valid, exp_fv()); end
        end
        in_valid = 1'b0;
        total++; if (fa_flat[DW-1:0] !== first) begin bad++; $display("FAIL flush_fa0 got=%h exp=%h", fa_flat[DW-1:0], first); end
        total++; if ({fb_flat, fa_flat} !== exp_pair()) begin bad++; $display("FAIL flush_pair got=%h exp=%h", {fb_flat, fa_flat}, exp_pair()); end
        frame_ready = 1'b1; tick(); frame_ready = 1'b0;
    endtask

    task automatic test_simul();
        rst = 1'b1; tick(); rst = 1'b0;
        frame_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 4 * N - 1; i++) begin in_data = DW'($urandom); tick(); end
        frame_ready = 1'b1; in_data = DW'($urandom); tick();
        frame_ready = 1'b0; in_valid = 1'b0;
        total++; if (frame_valid !== 1'b1) begin bad++; $display("FAIL simul_fv got=%0b exp=1", frame_valid); end
        total++; if ({fb_flat, fa_flat} !== exp_pair()) begin bad++; $display("FAIL simul_pair got=%h exp=%h", {fb_flat, fa_flat}, exp_pair()); end
        total++; if (frame_cnt !== 16'd1) begin bad++; $display("FAIL simul_cnt got=%0d exp=1", frame_cnt); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL simul_ready got=%0b exp=1", in_ready); end
        in_valid = 1'b1;
        for (int i = 0; i < 2 * N; i++) begin in_data = DW'($urandom); tick(); end
        in_valid = 1'b0;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL simul_both_full got=%0b exp=0", in_ready); end
        for (int j = 0; j < 2; j++) begin
            total++; if (frame_valid !== 1'b1 || {fb_flat, fa_flat} !== exp_pair()) begin bad++; $display("FAIL simul_drain%0d fv=%0b got=%h exp=%h", j, frame_valid, {fb_flat, fa_flat}, exp_pair()); end
            frame_ready = 1'b1; tick(); frame_ready = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] s;
        frame_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 2 * N + 12; i++) begin in_data = DW'($urandom); tick(); end
        rst = 1'b1; tick();
        total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL rmid_fv got=%0b exp=0", frame_valid); end
        total++; if (fa_flat !== '0 || fb_flat !== '0) begin bad++; $display("FAIL rmid_data fa=%h fb=%h exp=0", fa_flat, fb_flat); end
        total++; if (frame_cnt !== 16'd0) begin bad++; $display("FAIL rmid_cnt got=%0d exp=0", frame_cnt); end
        rst = 1'b0;
        s = DW'($urandom);
        for (int i = 0; i < 2 * N; i++) begin in_data = (i == 0) ? s : DW'($urandom); tick(); end
        in_valid = 1'b0;
        total++; if (fa_flat[DW-1:0] !== s || frame_valid !== 1'b1) begin bad++; $display("FAIL rmid_fa0 got=%h fv=%0b exp=%h", fa_flat[DW-1:0], frame_valid, s); end
        frame_ready = 1'b1; tick(); frame_ready = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            in_valid    = ($urandom_range(0, 9) < 7);
            frame_ready = ($urandom_range(0, 9) < 5);
            flush       = ($urandom_range(0, 99) < 3);
            in_data     = DW'($urandom);
            tick();
            total++; if (in_ready !== exp_ready() || frame_valid !== exp_fv() || frame_cnt !== exp_cnt) begin bad++; $display("FAIL rand_ctrl cyc=%0d rdy=%0b/%0b fv=%0b/%0b cnt=%0d/%0d", i, in_ready, exp_ready(), frame_valid, exp_fv(), frame_cnt, exp_cnt); end
            if (exp_fv()) begin
                total++; if ({fb_flat, fa_flat} !== exp_pair()) begin bad++; $display("FAIL rand_pair cyc=%0d got=%h exp=%h", i, {fb_flat, fa_flat}, exp_pair()); end
            end
        end
        in_valid = 1'b0; frame_ready = 1'b0; flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_continuous();
        test_flush();
        test_simul();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
